// File: rtl/sync_fifo_pkg.sv
// Shared widths, defaults and read-mode encoding for the parametrised sync FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// DATA_W x DEPTH register-array storage: synchronous write, asynchronous read.
module fifo_mem_1r1w
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, almost-full/empty thresholds, sticky errors and
// an optional first-word-fall-through read port.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AFULL_THR  = DEPTH - 4,
  parameter int AEMPTY_THR = 4,
  parameter int FWFT       = 0,
  localparam int AW        = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam rd_mode_e     MODE     = (FWFT != 0) ? RD_FWFT : RD_STD;
  localparam logic [AW:0]  DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]  AFULL_C  = (AW+1)'(AFULL_THR);
  localparam logic [AW:0]  AEMPTY_C = (AW+1)'(AEMPTY_THR);
  localparam logic [AW:0]  ONE      = (AW+1)'(1);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
  end
  if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_THR must lie in 1..DEPTH");
  end
  if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_THR must lie in 0..DEPTH-1");
  end

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count_q;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem_rd_data;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;

  // Full blocks the write even when a read frees a slot on the same edge.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_mem_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      if (wr_acc && !rd_acc)      count_q <= count_q + ONE;
      else if (rd_acc && !wr_acc) count_q <= count_q - ONE;
      // A fresh error on the clearing edge keeps the flag set.
      overflow  <= (wr_en & full)  | (overflow  & ~err_clr);
      underflow <= (rd_en & empty) | (underflow & ~err_clr);
    end
  end

  if (MODE == RD_FWFT) begin : g_fwft
    assign rd_data  = mem_rd_data;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) data_q <= mem_rd_data;
      end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
  end

endmodule
